// File: rtl/lsh_pkg.sv
// Shared types and default geometry for the window loader / window hasher pair.
package lsh_pkg;

    typedef logic [1:0] base_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HASH  = 2'd1,
        SLIDE = 2'd2
    } loader_state_t;

    localparam int DEFAULT_WINDOW_SIZE = 128;
    localparam int DEFAULT_STRIDE      = 64;

    // Width of a counter that must hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/window_loader_if.sv
// Base-stream and hasher handshake bundle for window_loader.
interface window_loader_if
    import lsh_pkg::*;
#(
    parameter int WINDOW_SIZE = DEFAULT_WINDOW_SIZE
) ();

    base_t                   base_in;
    logic                    base_valid;
    logic                    base_last;
    logic                    base_ready;
    base_t [0:WINDOW_SIZE-1] window;
    logic                    ready_for_hashing;
    logic                    hashing_is_done;
    logic [15:0]             window_index;
    logic                    seq_done;

    // Master: base source plus hasher side.
    modport master (
        output base_in,
        output base_valid,
        output base_last,
        output hashing_is_done,
        input  base_ready,
        input  window,
        input  ready_for_hashing,
        input  window_index,
        input  seq_done
    );

    // Slave: the loader itself.
    modport slave (
        input  base_in,
        input  base_valid,
        input  base_last,
        input  hashing_is_done,
        output base_ready,
        output window,
        output ready_for_hashing,
        output window_index,
        output seq_done
    );

endinterface

// File: rtl/window_shift_reg.sv
// WINDOW_SIZE-deep base shift register; index 0 is the oldest base, new bases enter at the top.
module window_shift_reg
    import lsh_pkg::*;
#(
    parameter int WINDOW_SIZE = DEFAULT_WINDOW_SIZE
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic                    shift_en,
    input  base_t                   din,
    output base_t [0:WINDOW_SIZE-1] window
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            window <= '0;
        end else if (shift_en) begin
            window <= {window[1:WINDOW_SIZE-1], din};
        end
    end

endmodule

// File: rtl/window_loader.sv
// Assembles a 2-bit base stream into sliding windows for the hasher.
// Optional WINDOW_LOADER_STATS_EN adds saturating windows_emitted / bases_dropped counters.
//
// state | meaning
// FILL  | collecting a fresh window of WINDOW_SIZE bases
// HASH  | window presented, waiting for hashing_is_done
// SLIDE | collecting STRIDE new bases for the next window
module window_loader
    import lsh_pkg::*;
#(
    parameter int WINDOW_SIZE = DEFAULT_WINDOW_SIZE,
    parameter int STRIDE      = DEFAULT_STRIDE
) (
    input  logic           clk,
    input  logic           reset,
    window_loader_if.slave bus
`ifdef WINDOW_LOADER_STATS_EN
    ,
    output logic [31:0]    windows_emitted,
    output logic [31:0]    bases_dropped
`endif
);

    localparam int CW = cnt_width(WINDOW_SIZE);
    localparam logic [CW-1:0] FILL_LAST  = CW'(WINDOW_SIZE - 1);
    localparam logic [CW-1:0] STRIDE_LAST = CW'(STRIDE - 1);

    loader_state_t state, state_nxt;
    logic [CW-1:0] fill_cnt, fill_cnt_nxt;
    logic [CW-1:0] slide_cnt, slide_cnt_nxt;
    logic [15:0]   window_index, window_index_nxt;
    logic          last_pend, last_pend_nxt;
    logic          seq_done_nxt;
    logic          base_ready_q;
    logic          rfh_q;
    logic          seq_done_q;
    logic          accept;

    assign accept                = bus.base_valid & base_ready_q;
    assign bus.base_ready        = base_ready_q;
    assign bus.ready_for_hashing = rfh_q;
    assign bus.window_index      = window_index;
    assign bus.seq_done          = seq_done_q;

    window_shift_reg #(
        .WINDOW_SIZE(WINDOW_SIZE)
    ) u_shift (
        .clk      (clk),
        .clr_n    (reset),
        .shift_en (accept),
        .din      (bus.base_in),
        .window   (bus.window)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= FILL;
            fill_cnt     <= '0;
            slide_cnt    <= '0;
            window_index <= '0;
            last_pend    <= 1'b0;
            base_ready_q <= 1'b1;
            rfh_q        <= 1'b0;
            seq_done_q   <= 1'b0;
        end else begin
            state        <= state_nxt;
            fill_cnt     <= fill_cnt_nxt;
            slide_cnt    <= slide_cnt_nxt;
            window_index <= window_index_nxt;
            last_pend    <= last_pend_nxt;
            base_ready_q <= (state_nxt != HASH);
            rfh_q        <= (state_nxt == HASH);
            seq_done_q   <= seq_done_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        fill_cnt_nxt     = fill_cnt;
        slide_cnt_nxt    = slide_cnt;
        window_index_nxt = window_index;
        last_pend_nxt    = last_pend;
        seq_done_nxt     = 1'b0;

        case (state)
            FILL: begin
                if (accept) begin
                    if (fill_cnt == FILL_LAST) begin
                        state_nxt     = HASH;
                        fill_cnt_nxt  = '0;
                        last_pend_nxt = bus.base_last;
                    end else if (bus.base_last) begin
                        seq_done_nxt     = 1'b1;
                        fill_cnt_nxt     = '0;
                        window_index_nxt = '0;
                    end else begin
                        fill_cnt_nxt = fill_cnt + 1'b1;
                    end
                end
            end

            HASH: begin
                if (bus.hashing_is_done) begin
                    if (last_pend) begin
                        state_nxt        = FILL;
                        seq_done_nxt     = 1'b1;
                        window_index_nxt = '0;
                        last_pend_nxt    = 1'b0;
                        fill_cnt_nxt     = '0;
                    end else begin
                        state_nxt        = SLIDE;
                        slide_cnt_nxt    = '0;
                        window_index_nxt = window_index + 16'd1;
                    end
                end
            end

            SLIDE: begin
                if (accept) begin
                    if (slide_cnt == STRIDE_LAST) begin
                        state_nxt     = HASH;
                        slide_cnt_nxt = '0;
                        last_pend_nxt = bus.base_last;
                    end else if (bus.base_last) begin
                        state_nxt        = FILL;
                        seq_done_nxt     = 1'b1;
                        slide_cnt_nxt    = '0;
                        fill_cnt_nxt     = '0;
                        window_index_nxt = '0;
                    end else begin
                        slide_cnt_nxt = slide_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = FILL;
            end
        endcase
    end

`ifdef WINDOW_LOADER_STATS_EN
    logic          enter_hash;
    logic [CW:0]   drop_cnt;
    logic [32:0]   emit_sum;
    logic [32:0]   drop_sum;

    // A seq_done raised outside HASH always means a partial window or stride was thrown away.
    assign enter_hash = (state_nxt == HASH) && (state != HASH);
    assign drop_cnt   = (seq_done_nxt && state != HASH)
                      ? ((state == FILL) ? {1'b0, fill_cnt} + 1'b1 : {1'b0, slide_cnt} + 1'b1)
                      : '0;
    assign emit_sum   = {1'b0, windows_emitted} + {32'd0, enter_hash};
    assign drop_sum   = {1'b0, bases_dropped} + 33'(drop_cnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            windows_emitted <= '0;
            bases_dropped   <= '0;
        end else begin
            windows_emitted <= emit_sum[32] ? 32'hFFFF_FFFF : emit_sum[31:0];
            bases_dropped   <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_window_loader.sv
// Self-checking bench for window_loader with WINDOW_SIZE=8, STRIDE=4.
module tb_window_loader;
    import lsh_pkg::*;

    localparam int W = 8;
    localparam int S = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    window_loader_if #(.WINDOW_SIZE(W)) bus ();

`ifdef WINDOW_LOADER_STATS_EN
    logic [31:0] windows_emitted;
    logic [31:0] bases_dropped;
`endif

    window_loader #(
        .WINDOW_SIZE(W),
        .STRIDE     (S)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef WINDOW_LOADER_STATS_EN
        ,
        .windows_emitted (windows_emitted),
        .bases_dropped   (bases_dropped)
`endif
    );

    logic [2*W-1:0] dw;
    assign dw = bus.window;

    int total = 0;
    int bad   = 0;

    // Reference model: remembers the last W accepted bases and how many more it needs.
    int     m_win[W];
    bit     m_rfh;
    bit     m_sd;
    bit     m_lp;
    int     m_need;
    int     m_got;
    int     m_idx;
    longint m_emit;
    longint m_drop;

    typedef struct {
        logic        v;
        logic [1:0]  b;
        logic        l;
        logic        d;
        logic        e_rdy;
        logic        e_rfh;
        logic        e_sd;
        logic [15:0] e_idx;
        logic        cw;
        logic [15:0] e_win;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model_win();
        logic [2*W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) r[2*(W-1-i) +: 2] = 2'(m_win[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < W; i++) m_win[i] = 0;
        m_rfh = 0; m_sd = 0; m_lp = 0;
        m_need = W; m_got = 0; m_idx = 0;
        m_emit = 0; m_drop = 0;
    endtask

    task automatic model_edge(input bit v, input logic [1:0] b, input bit l, input bit d);
        bit was_rfh;
        was_rfh = m_rfh;
        m_sd = 0;
        if (v && !was_rfh) begin
            for (int i = 0; i < W-1; i++) m_win[i] = m_win[i+1];
            m_win[W-1] = int'(b);
            m_got++;
            if (m_got == m_need) begin
                m_rfh = 1; m_lp = l; m_got = 0; m_emit++;
            end else if (l) begin
                m_sd = 1; m_drop += m_got; m_got = 0; m_need = W; m_idx = 0;
            end
        end
        if (was_rfh && d) begin
            m_rfh = 0;
            if (m_lp) begin
                m_sd = 1; m_idx = 0; m_need = W; m_lp = 0;
            end else begin
                m_idx = (m_idx + 1) % 65536;
                m_need = S;
            end
        end
    endtask

    task automatic check_model();
        check("m_ready", 64'(bus.base_ready), 64'(!m_rfh));
        check("m_rfh", 64'(bus.ready_for_hashing), 64'(m_rfh));
        check("m_seq_done", 64'(bus.seq_done), 64'(m_sd));
        check("m_index", 64'(bus.window_index), 64'(m_idx));
        check("m_window", 64'(dw), 64'(model_win()));
    endtask

    // Drive one cycle of inputs from a negedge and check one negedge later.
    task automatic step(input bit v, input logic [1:0] b, input bit l, input bit d);
        bus.base_valid      = v;
        bus.base_in         = b;
        bus.base_last       = l;
        bus.hashing_is_done = d;
        model_edge(v, b, l, d);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        bus.base_valid = 0; bus.base_in = 0; bus.base_last = 0; bus.hashing_is_done = 0;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [2*W-1:0] w0;

        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 2'(i % 4), 1'b0, 1'b0, 1'(i != 7), 1'(i == 7), 1'b0, 16'd0, 1'(i == 7), 16'h1B1B};
        tbl[8] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 16'h1B1B};
        tbl[9] = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0, 16'h0000};
        for (int i = 10; i < 14; i++)
            tbl[i] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'(i != 13), 1'(i == 13), 1'b0, 16'd1, 1'(i == 13), 16'h1BFF};

        // Reset values
        bus.base_valid = 0; bus.base_in = 0; bus.base_last = 0; bus.hashing_is_done = 0;
        reset = 1'b0;
        model_reset();
        #12;
        check("rst_ready", 64'(bus.base_ready), 64'd1);
        check("rst_rfh", 64'(bus.ready_for_hashing), 64'd0);
        check("rst_seq_done", 64'(bus.seq_done), 64'd0);
        check("rst_index", 64'(bus.window_index), 64'd0);
        check("rst_window", 64'(dw), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Cold fill then one slide
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].b, tbl[i].l, tbl[i].d);
            check("tbl_ready", 64'(bus.base_ready), 64'(tbl[i].e_rdy));
            check("tbl_rfh", 64'(bus.ready_for_hashing), 64'(tbl[i].e_rfh));
            check("tbl_seq_done", 64'(bus.seq_done), 64'(tbl[i].e_sd));
            check("tbl_index", 64'(bus.window_index), 64'(tbl[i].e_idx));
            if (tbl[i].cw) check("tbl_window", 64'(dw), 64'(tbl[i].e_win));
        end

        // Reset while a window is presented
        reset = 1'b0;
        bus.base_valid = 0; bus.hashing_is_done = 0; bus.base_last = 0;
        model_reset();
        #1;
        check("midrst_rfh", 64'(bus.ready_for_hashing), 64'd0);
        check("midrst_window", 64'(dw), 64'd0);
        check("midrst_index", 64'(bus.window_index), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(0, 2'd0, 0, 0);
        check("postrst_ready", 64'(bus.base_ready), 64'd1);

        // Early last discards a partial window
        for (int k = 0; k < 5; k++) step(1, 2'(k % 4), k == 4, 0);
        check("early_seq_done", 64'(bus.seq_done), 64'd1);
        check("early_rfh", 64'(bus.ready_for_hashing), 64'd0);
        step(0, 2'd0, 0, 0);
        check("early_sd_clear", 64'(bus.seq_done), 64'd0);
`ifdef WINDOW_LOADER_STATS_EN
        check("early_dropped", 64'(bases_dropped), 64'd5);
`endif

        // Last on the completing base
        for (int k = 0; k < 8; k++) step(1, 2'(k % 4), k == 7, 0);
        check("lastc_rfh", 64'(bus.ready_for_hashing), 64'd1);
        check("lastc_window", 64'(dw), 64'h1B1B);
        step(0, 2'd0, 0, 1);
        check("lastc_seq_done", 64'(bus.seq_done), 64'd1);
        check("lastc_ready", 64'(bus.base_ready), 64'd1);
        check("lastc_index", 64'(bus.window_index), 64'd0);
        for (int k = 0; k < 7; k++) step(1, 2'd2, 0, 0);
        check("lastc_in_fill", 64'(bus.ready_for_hashing), 64'd0);
        step(1, 2'd1, 0, 0);
        check("lastc_refill", 64'(bus.ready_for_hashing), 64'd1);

        // Stall with valid held high
        w0 = dw;
        for (int k = 0; k < 50; k++) step(1, 2'd2, 0, 0);
        check("stall_window", 64'(dw), 64'(w0));
        check("stall_ready", 64'(bus.base_ready), 64'd0);
        step(0, 2'd0, 0, 1);
        check("stall_index", 64'(bus.window_index), 64'd1);
        step(1, 2'd0, 0, 0);
        step(1, 2'd0, 1, 0);
        check("slide_drop_sd", 64'(bus.seq_done), 64'd1);
        check("slide_drop_idx", 64'(bus.window_index), 64'd0);

        // Stray done while filling
        for (int k = 0; k < 3; k++) step(1, 2'd1, 0, 0);
        step(0, 2'd0, 0, 1);
        check("stray_rfh", 64'(bus.ready_for_hashing), 64'd0);
        check("stray_ready", 64'(bus.base_ready), 64'd1);
        for (int k = 0; k < 4; k++) step(1, 2'd3, 0, 0);
        check("stray_not_yet", 64'(bus.ready_for_hashing), 64'd0);
        step(1, 2'd3, 0, 0);
        check("stray_window_done", 64'(bus.ready_for_hashing), 64'd1);
`ifdef WINDOW_LOADER_STATS_EN
        check("stats_emitted", 64'(windows_emitted), 64'd3);
        check("stats_dropped", 64'(bases_dropped), 64'd7);
`endif

        // Randomised run against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
        end
`ifdef WINDOW_LOADER_STATS_EN
        check("rand_emitted", 64'(windows_emitted), 64'(m_emit));
        check("rand_dropped", 64'(bases_dropped), 64'(m_drop));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/window_loader.md
# window_loader

Upstream feeder of `window_hasher`. It accepts a stream of 2-bit nucleotide codes under a valid/ready handshake and assembles them into a `WINDOW_SIZE`-entry window. When a window is complete it presents the window with `ready_for_hashing` and stalls until `hashing_is_done`. It then slides the window forward by `STRIDE` bases, or restarts at the end of a sequence.

## Interface
- `WINDOW_SIZE`, 128, bases per window; matches hasher.
- `STRIDE`, 64, new bases between consecutive windows of one sequence; legal range 1..`WINDOW_SIZE`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `base_in` input 2: nucleotide code.
- `base_valid` input 1: `base_in` valid.
- `base_last` input 1: qualifies `base_in` as the final base of the sequence.
- `base_ready` output 1: loader accepts a base this cycle.
- `window` output 2 × [0:`WINDOW_SIZE`-1]: index 0 holds the oldest base, `WINDOW_SIZE`-1 the newest.
- `ready_for_hashing` output 1: window valid, level held.
- `hashing_is_done` input 1: one-cycle pulse from the hasher.
- `window_index` output 16: ordinal of the presented window within the current sequence.
- `seq_done` output 1: one-cycle pulse at end-of-sequence handling.

## Operation
- A base is accepted on a rising edge with `base_valid && base_ready`. Accepted bases shift in at index `WINDOW_SIZE`-1, and every entry moves down by one.
- The FSM uses `lsh_pkg::loader_state_t` and has three states: FILL, HASH and SLIDE.
- **FILL**
  - `base_ready`=1; `fill_cnt` counts 0..`WINDOW_SIZE`.
  - Accepting base number `WINDOW_SIZE` moves the FSM to HASH.
  - `base_last` on an earlier base discards the partial window:
    - `seq_done` pulses;
    - `fill_cnt`=0;
    - `window_index`=0;
    - the FSM stays in FILL.
- **HASH**
  - `base_ready`=0 and `ready_for_hashing`=1; `window` is frozen.
  - On `hashing_is_done`:
    - if the `last_pend` flag is set, go to FILL, pulse `seq_done`, and clear `window_index` and `last_pend`;
    - otherwise go to SLIDE and increment `window_index`.
- **SLIDE**
  - `base_ready`=1; `slide_cnt` counts accepted bases.
  - Accepting base number `STRIDE` moves the FSM to HASH.
  - `base_last` on an earlier base drops the partial stride: `seq_done` pulses and the FSM enters FILL with counters cleared.
- `base_last` on the base that completes a window (FILL or SLIDE) sets `last_pend`. That window is still hashed.
- `hashing_is_done` outside HASH is ignored.
- `base_valid` with `base_ready`=0 is not consumed. The source holds the base.
- `window_index` wraps from 65535 to 0.
- Counter widths are `$clog2(WINDOW_SIZE+1)`.

## Timing
- Reset values:
  - state FILL;
  - `window` all 0;
  - `base_ready`=1;
  - `ready_for_hashing`=0;
  - `window_index`=0;
  - `seq_done`=0;
  - all counters and flags 0.
- `base_ready` is registered. It drops in the cycle after the completing base is accepted, and `ready_for_hashing` rises in that same cycle.
- From a cold start the first window appears `WINDOW_SIZE` accepting cycles plus 1 cycle after the first accepted base.
- `ready_for_hashing` falls in the cycle after `hashing_is_done` is sampled. `base_ready` rises in that same cycle.
- Back-to-back windows with continuous valid take `STRIDE` + 1 + hasher latency cycles.
- `seq_done` pulses for exactly one cycle, in the cycle after the triggering edge.
- Reset asserted mid-operation immediately forces all reset values, including when `ready_for_hashing`=1.

## Configuration
- Macro `WINDOW_LOADER_STATS_EN`.
- Defined: adds the following outputs, both saturating and cleared only by reset:
  - `windows_emitted` [31:0], incremented on each HASH entry;
  - `bases_dropped` [31:0], incremented by the base count of each discarded partial window or partial stride.
- Undefined: both ports and their logic are absent; the rest of the behaviour is identical.

## Structure
- `lsh_pkg`:
  - `base_t` (logic [1:0]);
  - `loader_state_t` enum (FILL, HASH, SLIDE);
  - `WINDOW_SIZE`/`STRIDE` defaults, shared with `window_hasher`.
- One sub-module, `window_shift_reg`: parameterised `WINDOW_SIZE`-deep 2-bit shift register with shift enable and async active-low clear.
- The FSM, counters and flags live in `window_loader`.

## Test plan
Bench parameters: `WINDOW_SIZE`=8, `STRIDE`=4.

- **Cold fill:** stream bases 0,1,2,3,0,1,2,3 continuously.
  - `ready_for_hashing`=1 on cycle 9 with `window`={0,1,2,3,0,1,2,3} and `window_index`=0.
  - `base_ready`=0 until the done pulse.
- **Slide:** after the first window, pulse done and send 3,3,3,3.
  - The second window is {0,1,2,3,3,3,3,3} with `window_index`=1.
- **Early last:** send 5 bases with `base_last` on the 5th.
  - `seq_done` pulses once; no `ready_for_hashing`.
  - With `WINDOW_LOADER_STATS_EN`: `bases_dropped`=5.
- **Last on completing base:** `base_last` on the 8th base.
  - The window is presented; after done, `seq_done` pulses and the state is FILL with `window_index`=0.
- **Stall:** hold done low for 50 cycles while `base_valid`=1.
  - No base accepted and `window` is unchanged.
  - A stray done pulse while in FILL has no effect.
- **Reset mid-HASH:** drive `reset` low.
  - `ready_for_hashing`=0 and `window` all 0 immediately.
  - `base_ready`=1 after release.
